multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle RV32I datapath. It replaces the single-cycle combinational main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states over a single shared instruction/data memory port with a ready handshake.
- Produces every datapath enable and mux select, and traps on illegal opcodes or memory timeouts.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles with mem_ready low before bus error; 0 disables the timeout.
- TMO_W, $clog2(MEM_TIMEOUT+1): timeout counter width, derived; floor of 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode field of the latched instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  store strobe
- IRWrite  out  1  instruction register load
- PCWrite  out  1  PC load
- RegWrite  out  1  register file write
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  ALU B select: 00 rs2, 01 imm, 10 constant 4
- ALUOP  out  2  00 add, 01 subtract/branch, 10 funct-decoded
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- Illegal  out  1  sticky: unsupported opcode trapped
- BusErr  out  1  sticky: memory timeout trapped

Behaviour:
- Reset: asynchronous on rst_n low. State goes to FETCH; the counter and sticky flags clear. All outputs are forced to 0 while rst_n is low. FETCH outputs apply from the first clock edge after release.
- Outputs are Moore-decoded from the state. Exceptions: IRWrite, PCWrite and state advance in memory states are qualified by mem_ready. Any output not listed for a state is 0.
- PCWrite = PCUpdate | (Branch & Zero).
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOP=00, ResultSrc=10. IRWrite and PCUpdate are each equal to mem_ready. Advance to DECODE on mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> TRAP with Illegal set
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOP=00. ImmSrc is 00 for lw, 01 for sw. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. On mem_ready -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1, ResultSrc=00. MemWrite is held for the whole wait. On mem_ready -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOP=10, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOP=10, ImmSrc=00, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOP=01, ResultSrc=00, Branch=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1, ImmSrc=11, then ALUWB.
- Latency with zero-wait memory: lw 5, sw 4, R 4, I 4, beq 3, jal 4 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- Timeout counter:
  - Clears on entry to any memory state and whenever mem_ready is high.
  - Increments each cycle in a memory state with mem_ready low.
  - If it reaches MEM_TIMEOUT while mem_ready is still low -> TRAP with BusErr set.
  - If mem_ready rises on the same cycle the limit is reached, mem_ready wins and there is no error.
- TRAP: all control outputs are 0 and the sticky flags hold. Exit only via reset.
- Reset mid-access: mem_req and MemWrite drop immediately (asynchronous).

Optional Feature:
- Macro: MC_CTRL_JAL_EN.
- Defined: JAL state and the op 1101111 decode path are present.
- Undefined: 1101111 traps as Illegal, and ImmSrc=11 is never driven.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL
  - state enum
  - ALUOP, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings
- One sub-module, mc_wait_timer: parametrised saturating wait counter with clear, enable and expired output.

Test Plan:
- Reset is held, then released with op=0000011 and mem_ready=1 -> sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and ResultSrc=01 in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 held for 4 cycles. Return to FETCH after mem_ready goes high.
- beq with Zero=1 -> PCWrite=1 in cycle 3. Repeat with Zero=0 -> PCWrite=0.
- op=1110011 -> Illegal=1 after DECODE. All controls stay 0 for 20 cycles, then clear on rst_n low.
- MEM_TIMEOUT=15 with mem_ready stuck low in FETCH -> BusErr=1 at the 15th wait cycle. A second run with mem_ready rising on the 15th cycle -> no error and DECODE is reached.
- jal with MC_CTRL_JAL_EN defined -> 4 cycles, ImmSrc=11, RegWrite in cycle 4. With the macro undefined -> Illegal=1.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - opcodes, FSM states and datapath select encodings for the multi-cycle RV32I controller.
// MC_CTRL_JAL_EN adds the JAL state and the J-type immediate encoding.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
`ifdef MC_CTRL_JAL_EN
    S_JAL,
`endif
    S_TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
`ifdef MC_CTRL_JAL_EN
  localparam logic [1:0] IMM_J = 2'b11;
`endif

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // States that own the shared memory port and wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - saturating wait-cycle counter; expired flags the cycle that would reach LIMIT.
module mc_wait_timer #(
  parameter int LIMIT = 15,
  parameter int W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt counts earlier wait cycles, so this wait cycle is the LIMIT-th one.
  assign expired = (LIMIT > 0) && en && (cnt == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with shared memory port and trap handling.
// Optional JAL support is built when MC_CTRL_JAL_EN is defined.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOP,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic       BusErr
);

  state_t     state;
  state_t     state_next;
  logic       run;
  logic       illegal_q;
  logic       buserr_q;
  logic       set_ill;
  logic       set_bus;
  logic       mem_state;
  logic       tmo_expired;
  logic       pc_update;
  logic       branch;

  logic       c_mem_req;
  logic       c_adr_src;
  logic       c_mem_write;
  logic       c_ir_write;
  logic       c_pc_write;
  logic       c_reg_write;
  logic [1:0] c_result_src;
  logic [1:0] c_alu_src_a;
  logic [1:0] c_alu_src_b;
  logic [1:0] c_alu_op;
  logic [1:0] c_imm_src;

  assign mem_state = is_mem_state(state);

  mc_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TMO_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!run || !mem_state || mem_ready),
    .en      (run && mem_state && !mem_ready),
    .expired (tmo_expired)
  );

  // run rises on the first edge after reset release; until then the FSM holds and outputs stay 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      run       <= 1'b0;
      illegal_q <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        state <= state_next;
        if (set_ill) illegal_q <= 1'b1;
        if (set_bus) buserr_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    set_ill      = 1'b0;
    set_bus      = 1'b0;
    pc_update    = 1'b0;
    branch       = 1'b0;
    c_mem_req    = 1'b0;
    c_adr_src    = 1'b0;
    c_mem_write  = 1'b0;
    c_ir_write   = 1'b0;
    c_reg_write  = 1'b0;
    c_result_src = RES_ALUOUT;
    c_alu_src_a  = SRCA_PC;
    c_alu_src_b  = SRCB_RS2;
    c_alu_op     = ALU_ADD;
    c_imm_src    = IMM_I;

    case (state)
      S_FETCH: begin
        c_mem_req    = 1'b1;
        c_alu_src_b  = SRCB_FOUR;
        c_result_src = RES_ALURESULT;
        c_ir_write   = mem_ready;
        pc_update    = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        c_alu_src_a = SRCA_OLDPC;
        c_alu_src_b = SRCB_IMM;
        c_imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_BRANCH:         state_next = S_BEQ;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:            state_next = S_JAL;
`else
          OP_JAL: begin
            state_next = S_TRAP;
            set_ill    = 1'b1;
          end
`endif
          default: begin
            state_next = S_TRAP;
            set_ill    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        c_alu_src_a = SRCA_RS1;
        c_alu_src_b = SRCB_IMM;
        if (op == OP_STORE) begin
          c_imm_src  = IMM_S;
          state_next = S_MEMWRITE;
        end else begin
          state_next = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        c_mem_req = 1'b1;
        c_adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        c_result_src = RES_DATA;
        c_reg_write  = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        c_mem_req   = 1'b1;
        c_adr_src   = 1'b1;
        c_mem_write = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECUTER: begin
        c_alu_src_a = SRCA_RS1;
        c_alu_op    = ALU_FUNCT;
        state_next  = S_ALUWB;
      end
      S_EXECUTEI: begin
        c_alu_src_a = SRCA_RS1;
        c_alu_src_b = SRCB_IMM;
        c_alu_op    = ALU_FUNCT;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        c_reg_write = 1'b1;
        state_next  = S_FETCH;
      end
      S_BEQ: begin
        c_alu_src_a = SRCA_RS1;
        c_alu_op    = ALU_SUB;
        branch      = 1'b1;
        state_next  = S_FETCH;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        c_alu_src_a = SRCA_OLDPC;
        c_alu_src_b = SRCB_FOUR;
        c_imm_src   = IMM_J;
        pc_update   = 1'b1;
        state_next  = S_ALUWB;
      end
`endif
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_TRAP;
    endcase

    // A completing access always beats the timeout.
    if (mem_state && !mem_ready && tmo_expired) begin
      state_next = S_TRAP;
      set_bus    = 1'b1;
    end

    c_pc_write = pc_update | (branch & Zero);
  end

  assign mem_req   = run & c_mem_req;
  assign AdrSrc    = run & c_adr_src;
  assign MemWrite  = run & c_mem_write;
  assign IRWrite   = run & c_ir_write;
  assign PCWrite   = run & c_pc_write;
  assign RegWrite  = run & c_reg_write;
  assign ResultSrc = run ? c_result_src : 2'b00;
  assign ALUSrcA   = run ? c_alu_src_a  : 2'b00;
  assign ALUSrcB   = run ? c_alu_src_b  : 2'b00;
  assign ALUOP     = run ? c_alu_op     : 2'b00;
  assign ImmSrc    = run ? c_imm_src    : 2'b00;
  assign Illegal   = illegal_q;
  assign BusErr    = buserr_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller.
// Expected controls come from a per-phase table and an instruction-to-phase-list model.
module tb_multicycle_controller;

  localparam int TMO = 15;

  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_RTYPE  = 7'b0110011;
  localparam logic [6:0] T_ITYPE  = 7'b0010011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;

  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
  localparam int P_XR = 6, P_XI = 7, P_AWB = 8, P_BEQ = 9, P_JAL = 10, P_TRAP = 11;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOP, ImmSrc;
  logic       Illegal, BusErr;
  logic [17:0] dut_vec;

  int    checks = 0;
  int    errors = 0;
  int    zforce = -1;
  logic  exp_ill = 1'b0;
  logic  exp_bus = 1'b0;
  string tname = "none";

  multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOP     (ALUOP),
    .ImmSrc    (ImmSrc),
    .Illegal   (Illegal),
    .BusErr    (BusErr)
  );

  assign dut_vec = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOP, ImmSrc, Illegal, BusErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control values the datapath needs in each instruction phase.
  function automatic logic [17:0] exp_ctrl(input int ph, input logic mr, input logic z,
                                           input logic [6:0] o, input logic ill, input logic be);
    logic req, adr, mw, irw, pcw, rw;
    logic [1:0] rs, sa, sb, aop, imm;
    req = 0; adr = 0; mw = 0; irw = 0; pcw = 0; rw = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00; imm = 2'b00;
    case (ph)
      P_F:   begin req = 1; sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      P_D:   begin sa = 2'b01; sb = 2'b01; imm = 2'b10; end
      P_MA:  begin sa = 2'b10; sb = 2'b01; imm = (o == T_STORE) ? 2'b01 : 2'b00; end
      P_MR:  begin req = 1; adr = 1; end
      P_MWB: begin rs = 2'b01; rw = 1; end
      P_MW:  begin req = 1; adr = 1; mw = 1; end
      P_XR:  begin sa = 2'b10; aop = 2'b10; end
      P_XI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      P_AWB: begin rw = 1; end
      P_BEQ: begin sa = 2'b10; aop = 2'b01; pcw = z; end
      P_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; imm = 2'b11; end
      default: ;
    endcase
    return {req, adr, mw, irw, pcw, rw, rs, sa, sb, aop, imm, ill, be};
  endfunction

  task automatic cycle(input int ph, input logic mr);
    logic [17:0] e;
    @(negedge clk);
    mem_ready = mr;
    Zero = (zforce < 0) ? 1'($urandom_range(0, 1)) : zforce[0];
    #1;
    e = exp_ctrl(ph, mr, Zero, op, exp_ill, exp_bus);
    checks++;
    if (dut_vec !== e) begin
      errors++;
      $display("FAIL %s phase=%0d got=%h expected=%h", tname, ph, dut_vec, e);
    end
  endtask

  task automatic do_phase(input int ph, input int waits);
    if (ph == P_F || ph == P_MR || ph == P_MW) begin
      for (int i = 0; i < waits; i++) cycle(ph, 1'b0);
      cycle(ph, 1'b1);
    end else begin
      cycle(ph, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input int wf, input int wm);
    op = o;
    do_phase(P_F, wf);
    do_phase(P_D, 0);
    case (o)
      T_LOAD:   begin do_phase(P_MA, 0); do_phase(P_MR, wm); do_phase(P_MWB, 0); end
      T_STORE:  begin do_phase(P_MA, 0); do_phase(P_MW, wm); end
      T_RTYPE:  begin do_phase(P_XR, 0); do_phase(P_AWB, 0); end
      T_ITYPE:  begin do_phase(P_XI, 0); do_phase(P_AWB, 0); end
      T_BRANCH: do_phase(P_BEQ, 0);
`ifdef MC_CTRL_JAL_EN
      T_JAL:    begin do_phase(P_JAL, 0); do_phase(P_AWB, 0); end
`endif
      default: begin
        exp_ill = 1'b1;
        repeat (3) do_phase(P_TRAP, 0);
      end
    endcase
  endtask

  task automatic check_zero(input string what);
    checks++;
    if (dut_vec !== 18'd0) begin
      errors++;
      $display("FAIL %s got=%h expected=0", what, dut_vec);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    op = T_LOAD;
    #1;
    exp_ill = 1'b0;
    exp_bus = 1'b0;
    check_zero("reset_assert");
    repeat (2) @(negedge clk);
    #1 check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_zero("reset_release");
  endtask

  task automatic test_reset();
    tname = "reset_lw";
    do_reset();
    run_instr(T_LOAD, 0, 0);
  endtask

  task automatic test_sw_wait();
    tname = "sw_wait";
    run_instr(T_STORE, 0, 3);
    run_instr(T_RTYPE, 0, 0);
  endtask

  task automatic test_beq();
    tname = "beq_taken";
    zforce = 1;
    run_instr(T_BRANCH, 0, 0);
    tname = "beq_not_taken";
    zforce = 0;
    run_instr(T_BRANCH, 0, 0);
    zforce = -1;
  endtask

  task automatic test_illegal();
    tname = "illegal";
    do_reset();
    op = T_SYSTEM;
    do_phase(P_F, 0);
    do_phase(P_D, 0);
    exp_ill = 1'b1;
    repeat (20) do_phase(P_TRAP, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero("illegal_clear");
  endtask

  task automatic test_timeout();
    tname = "timeout";
    do_reset();
    op = T_RTYPE;
    for (int i = 0; i < TMO; i++) cycle(P_F, 1'b0);
    exp_bus = 1'b1;
    repeat (3) do_phase(P_TRAP, 0);
    tname = "timeout_edge";
    do_reset();
    run_instr(T_RTYPE, TMO - 1, 0);
    tname = "timeout_edge_mem";
    run_instr(T_LOAD, 0, TMO - 1);
    run_instr(T_STORE, TMO - 1, TMO - 1);
  endtask

  task automatic test_jal();
    tname = "jal";
    do_reset();
    run_instr(T_JAL, 0, 0);
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid";
    do_reset();
    op = T_STORE;
    do_phase(P_F, 0);
    do_phase(P_D, 0);
    do_phase(P_MA, 0);
    cycle(P_MW, 1'b0);
    cycle(P_MW, 1'b0);
    #2;
    rst_n = 1'b0;
    #1 check_zero("reset_mid_access");
  endtask

  task automatic test_random();
    logic [6:0] ops [$];
    tname = "random";
    ops = '{T_LOAD, T_STORE, T_RTYPE, T_ITYPE, T_BRANCH};
`ifdef MC_CTRL_JAL_EN
    ops.push_back(T_JAL);
`endif
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int wf, wm;
      wf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO - 1)) : 0;
      wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO - 1)) : 0;
      run_instr(ops[$urandom_range(0, ops.size() - 1)], wf, wm);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    op = 7'd0;
    Zero = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_jal();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
